// File: rtl/crc8_frame_serializer_if.sv
// Handshake and serial-stream bundle for crc8_frame_serializer.
// master = word source / stream consumer, slave = the serializer itself.
interface crc8_frame_serializer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_hold;
  logic              ser_data;
  logic              ser_enable;
  logic              ser_crc_phase;
  logic              ser_last;
  logic [7:0]        crc_out;
  logic              frame_done;

  modport master (
    output in_data, in_valid, ser_hold,
    input  in_ready, ser_data, ser_enable, ser_crc_phase, ser_last, crc_out, frame_done
  );

  modport slave (
    input  in_data, in_valid, ser_hold,
    output in_ready, ser_data, ser_enable, ser_crc_phase, ser_last, crc_out, frame_done
  );
endinterface

// File: rtl/crc8_frame_serializer.sv
// Serializes a parallel word MSB-first and appends its CRC-8, forming one frame
// of DATA_W+8 qualified bits followed by a one-cycle frame_done pulse.
module crc8_frame_serializer #(
  parameter int         DATA_W = 16,
  parameter logic [7:0] POLY   = 8'h07,
  parameter logic [7:0] INIT   = 8'h00
) (
  input logic                   clk,
  input logic                   reset,
  crc8_frame_serializer_if.slave bus
);
  localparam int SW = (DATA_W < 8) ? 8 : DATA_W;
  localparam int CW = (DATA_W > 8) ? $clog2(DATA_W) : 3;

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t          state_reg;
  logic [SW-1:0]   shift_reg;
  logic [CW-1:0]   cnt_reg;
  logic [7:0]      crc_reg;
  logic [7:0]      crc_out_reg;
  logic            ready_reg;
  logic            data_reg;
  logic            enable_reg;
  logic            crc_phase_reg;
  logic            last_reg;
  logic            done_reg;

  logic            accept;
  logic [7:0]      crc_next;
  logic [SW-1:0]   load_word;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ (POLY & {8{c[7] ^ b}});
  endfunction

  assign accept    = bus.in_valid && bus.in_ready;
  assign crc_next  = crc_step(crc_reg, shift_reg[SW-1]);
  assign load_word = SW'(bus.in_data) << (SW - DATA_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      crc_reg       <= '0;
      crc_out_reg   <= '0;
      ready_reg     <= 1'b0;
      data_reg      <= 1'b0;
      enable_reg    <= 1'b0;
      crc_phase_reg <= 1'b0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else if (!bus.ser_hold) begin
      // shift_reg[SW-1] is always the bit currently presented on ser_data
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (accept) begin
            state_reg  <= DATA;
            shift_reg  <= load_word;
            crc_reg    <= INIT;
            cnt_reg    <= CW'(DATA_W - 1);
            data_reg   <= bus.in_data[DATA_W-1];
            enable_reg <= 1'b1;
            ready_reg  <= 1'b0;
          end
        end
        DATA: begin
          crc_reg <= crc_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg              <= CRC;
            crc_out_reg            <= crc_next;
            shift_reg[SW-1 -: 8]   <= crc_next;
            cnt_reg                <= CW'(7);
            data_reg               <= crc_next[7];
            crc_phase_reg          <= 1'b1;
          end else begin
            shift_reg <= shift_reg << 1;
            data_reg  <= shift_reg[SW-2];
          end
        end
        CRC: begin
          shift_reg <= shift_reg << 1;
          cnt_reg   <= cnt_reg - 1'b1;
          data_reg  <= shift_reg[SW-2];
          if (cnt_reg == CW'(1))
            last_reg <= 1'b1;
          if (cnt_reg == '0) begin
            state_reg     <= DONE;
            cnt_reg       <= '0;
            data_reg      <= 1'b0;
            enable_reg    <= 1'b0;
            crc_phase_reg <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall gating is applied in the same cycle so a held bit is never counted twice downstream.
  assign bus.in_ready      = ready_reg && !bus.ser_hold;
  assign bus.ser_enable    = enable_reg && !bus.ser_hold;
  assign bus.frame_done    = done_reg && !bus.ser_hold;
  assign bus.ser_data      = data_reg;
  assign bus.ser_crc_phase = crc_phase_reg;
  assign bus.ser_last      = last_reg;
  assign bus.crc_out       = crc_out_reg;
endmodule

// File: tb/tb_crc8_frame_serializer.sv
// Directed bench for crc8_frame_serializer with a serial CRC-8 generator model
// listening on ser_data/ser_enable.
module tb_crc8_frame_serializer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   last_acc;
  int   prev_acc;
  logic gen_clr;
  logic [7:0] gen_data;
  logic [7:0] gen_full;

  crc8_frame_serializer_if #(.DATA_W(16)) bus ();

  crc8_frame_serializer #(.DATA_W(16), .POLY(8'h07), .INIT(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gen_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ (8'h07 & {8{c[7] ^ b}});
  endfunction

  // Downstream CRC-8 generator: one over payload bits only, one over the whole frame.
  always @(posedge clk) begin
    if (gen_clr) begin
      gen_data <= 8'h00;
      gen_full <= 8'h00;
    end else if (bus.ser_enable) begin
      gen_full <= gen_step(gen_full, bus.ser_data);
      if (!bus.ser_crc_phase)
        gen_data <= gen_step(gen_data, bus.ser_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input logic [15:0] word, input logic [7:0] exp_crc,
                           input logic [7:0] prev_crc,
                           input int h1, input int n1, input int h2, input int n2,
                           input int abort_at, input logic next_valid,
                           input logic [15:0] next_word, input int exp_len);
    logic [23:0] bits;
    int nb, held1, held2, done_at;
    logic hold;
    bus.in_data  = word;
    bus.in_valid = 1'b1;
    bus.ser_hold = 1'b0;
    #1;
    chk("ready_before_accept", 64'(bus.in_ready), 64'd1);
    prev_acc = last_acc;
    last_acc = cyc;
    tick();
    bus.in_valid = next_valid;
    bus.in_data  = next_word;
    bits = '0; nb = 0; held1 = 0; held2 = 0; done_at = -1;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      if (nb == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_enable", 64'(bus.ser_enable), 64'd0);
        chk("abort_data", 64'(bus.ser_data), 64'd0);
        chk("abort_phase", 64'(bus.ser_crc_phase), 64'd0);
        chk("abort_last", 64'(bus.ser_last), 64'd0);
        chk("abort_ready", 64'(bus.in_ready), 64'd0);
        chk("abort_done", 64'(bus.frame_done), 64'd0);
        chk("abort_crc_out", 64'(bus.crc_out), 64'h00);
        return;
      end
      hold = (nb == h1 && held1 < n1) || (nb == h2 && held2 < n2);
      bus.ser_hold = hold;
      #1;
      if (hold) begin
        if (nb == h1 && held1 < n1) held1++;
        else held2++;
        chk("hold_enable_low", 64'(bus.ser_enable), 64'd0);
      end else if (bus.ser_enable) begin
        bits = {bits[22:0], bus.ser_data};
        chk("crc_phase_flag", 64'(bus.ser_crc_phase), 64'(nb >= 16));
        chk("last_flag", 64'(bus.ser_last), 64'(nb == 23));
        if (nb < 16) chk("crc_out_stable", 64'(bus.crc_out), 64'(prev_crc));
        nb++;
      end
      chk("busy_not_ready", 64'(bus.in_ready), 64'd0);
      if (bus.frame_done) begin
        done_at = c;
        chk("done_no_enable", 64'(bus.ser_enable), 64'd0);
      end
      tick();
      bus.ser_hold = 1'b0;
    end
    #1;
    chk("frame_len", 64'(done_at), 64'(exp_len));
    chk("frame_bits", 64'(bits), 64'({word, exp_crc}));
    chk("crc_out", 64'(bus.crc_out), 64'(exp_crc));
    chk("done_one_cycle", 64'(bus.frame_done), 64'd0);
    chk("ready_after_done", 64'(bus.in_ready), 64'd1);
    $display("frame in=%h crc_out=%h len=%0d bits=%h", word, bus.crc_out, done_at, bits);
  endtask

  task automatic clear_gen();
    gen_clr = 1'b1;
    tick();
    gen_clr = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_acc = 0; prev_acc = 0;
    gen_clr = 1'b1;
    reset = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.ser_hold = 1'b0;
    #2;
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_enable", 64'(bus.ser_enable), 64'd0);
    chk("rst_data", 64'(bus.ser_data), 64'd0);
    chk("rst_phase", 64'(bus.ser_crc_phase), 64'd0);
    chk("rst_last", 64'(bus.ser_last), 64'd0);
    chk("rst_done", 64'(bus.frame_done), 64'd0);
    chk("rst_crc_out", 64'(bus.crc_out), 64'h00);
    tick();
    tick();
    chk("rst_ready_held", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    tick();
    chk("ready_after_release", 64'(bus.in_ready), 64'd1);
    gen_clr = 1'b0;

    // 1: basic frame, generator on the line
    run_frame(16'hECB5, 8'hBD, 8'h00, -1, 0, -1, 0, -1, 1'b0, 16'h0000, 25);
    chk("gen_payload_crc", 64'(gen_data), 64'h BD);
    chk("gen_frame_residue", 64'(gen_full), 64'h00);
    $display("gen payload=%h frame=%h", gen_data, gen_full);

    // 2: all-zero and all-one payloads
    run_frame(16'h0000, 8'h00, 8'hBD, -1, 0, -1, 0, -1, 1'b0, 16'h0000, 25);
    run_frame(16'hFFFF, 8'h24, 8'h00, -1, 0, -1, 0, -1, 1'b0, 16'h0000, 25);

    // 3: back-to-back with in_valid held and in_data changed mid-frame
    run_frame(16'hECB5, 8'hBD, 8'h24, -1, 0, -1, 0, -1, 1'b1, 16'hFFFF, 25);
    run_frame(16'hFFFF, 8'h24, 8'hBD, -1, 0, -1, 0, -1, 1'b0, 16'h0000, 25);
    chk("accept_spacing", 64'(last_acc - prev_acc), 64'd26);
    $display("accept spacing=%0d", last_acc - prev_acc);

    // 4: stalls on data bit 5 (3 cycles) and crc bit 2 (2 cycles)
    clear_gen();
    run_frame(16'hECB5, 8'hBD, 8'h24, 5, 3, 18, 2, -1, 1'b0, 16'h0000, 30);
    chk("gen_hold_crc", 64'(gen_data), 64'hBD);

    // 5: asynchronous reset at data bit 9, then a clean frame
    run_frame(16'hECB5, 8'hBD, 8'hBD, -1, 0, -1, 0, 9, 1'b0, 16'h0000, 25);
    $display("abort at bit 9 crc_out=%h enable=%b", bus.crc_out, bus.ser_enable);
    tick();
    reset = 1'b1;
    tick();
    chk("ready_after_abort", 64'(bus.in_ready), 64'd1);
    chk("crc_out_after_abort", 64'(bus.crc_out), 64'h00);
    clear_gen();

    // 6: generator tied to the stream after the abort
    run_frame(16'hECB5, 8'hBD, 8'h00, -1, 0, -1, 0, -1, 1'b0, 16'h0000, 25);
    chk("gen_vs_crc_out", 64'(gen_data), 64'(bus.crc_out));
    chk("gen_payload_crc2", 64'(gen_data), 64'hBD);
    chk("gen_frame_residue2", 64'(gen_full), 64'h00);
    $display("gen payload=%h frame=%h", gen_data, gen_full);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc8_frame_serializer.md
Name: crc8_frame_serializer

Overview:
Upstream companion to the serial CRC-8 generator. Accepts a parallel data word over a valid/ready handshake, shifts it out MSB-first as a qualified serial bit stream, computes CRC-8 on the fly and appends the 8 CRC bits MSB-first to form a complete frame. Its serial data/enable outputs connect directly to the CRC-8 generator's data/enable inputs or to a line driver.

Parameters:
DATA_W, 16, payload width in bits (legal range 2..64)
POLY, 8'h07, CRC-8 polynomial without x^8 term (x^8+x^2+x+1)
INIT, 8'h00, CRC register value loaded at each frame accept

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  DATA_W  payload word, sampled on accept
in_valid  input  1  payload word valid
in_ready  output  1  block can accept a word
ser_hold  input  1  downstream stall; freezes the block while high
ser_data  output  1  serial bit, MSB-first
ser_enable  output  1  ser_data is a valid frame bit this cycle
ser_crc_phase  output  1  current bit is a CRC bit
ser_last  output  1  last bit of frame (final CRC bit)
crc_out  output  8  CRC of the most recent payload
frame_done  output  1  one-cycle pulse after last bit

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; bit counter=0; shift and CRC registers=0; in_ready=0 while asserted; ser_data, ser_enable, ser_crc_phase, ser_last, frame_done=0; crc_out=8'h00. The first rising clk after deassertion leaves in_ready=1.
- Registered outputs; in_ready = (state==IDLE) && !ser_hold.
- FSM states:
  - IDLE: accept when in_valid && in_ready. Load shift register with in_data, CRC register with INIT, counter with DATA_W-1; go to DATA.
  - DATA: 1 bit per unstalled cycle. ser_data=shift[DATA_W-1]; ser_enable=1; CRC update is crc <= {crc[6:0],1'b0} ^ (POLY & {8{crc[7]^bit}}). When counter hits 0, latch the updated CRC into crc_out and into the shift register's top 8 bits, set counter=7 and go to CRC.
  - CRC: ser_data=crc shift MSB; ser_enable=1; ser_crc_phase=1. On counter 0: ser_last=1, then go to DONE.
  - DONE: exactly one cycle. frame_done=1, ser_enable=0, then go to IDLE.
- Latency: first data bit appears on ser_data the cycle after accept. Frame occupies DATA_W+8 enabled cycles. Minimum accept-to-accept spacing is DATA_W+10 cycles.
- ser_hold=1: all registers hold; ser_enable is forced to 0 for that cycle. ser_data/ser_crc_phase/ser_last hold their values and no bit is consumed. In DONE, the frame_done pulse is delayed until hold releases and still lasts exactly one cycle.
- in_valid while not ready is ignored. in_data is not re-sampled mid-frame.
- crc_out is stable from the end of the DATA phase until the next frame's DATA phase ends.
- Asynchronous reset mid-frame aborts the frame immediately. No partial CRC is emitted and all outputs go to their reset values.

Test Plan:
1. Reset, then accept in_data=16'hECB5 -> ser_data on 16 enabled cycles = 1110_1100_1011_0101, then CRC bits 1011_1101 (0xBD) with ser_crc_phase=1, ser_last on the 24th enabled bit, crc_out=8'hBD, frame_done one cycle later.
2. in_data=16'h0000 -> 24 enabled zero bits, crc_out=8'h00. in_data=16'hFFFF -> crc_out=8'h24.
3. Back-to-back: in_valid held high with 0xECB5 then 0xFFFF -> second accept exactly 26 cycles after the first, second CRC=0x24, no overlap of ser_enable.
4. ser_hold pulsed 3 cycles during DATA bit 5 and 2 cycles during CRC bit 2 -> bit stream and CRC unchanged (0xBD), ser_enable=0 during holds, total frame lengthened by 5 cycles.
5. Assert reset low at DATA bit 9 -> outputs go to 0 immediately, in_ready=1 after release, a new 0xECB5 frame gives CRC 0xBD.
6. Tie the serializer to the CRC-8 generator (data/enable) for 0xECB5 -> generator crc equals crc_out (0xBD) after 16 data bits.
